// File: rtl/score_pkg.sv
// Shared types and constants for the two-digit BCD score counter.
package score_pkg;

  // Digit code that drives the seven-segment decoders to all-segments-off.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    NORMAL,
    BLINK_OFF,
    BLINK_ON
  } blink_state_t;

  // Replace a digit with the blank code when requested.
  function automatic bcd_digit_t show_digit(input bcd_digit_t value, input logic blank);
    return blank ? DIGIT_BLANK : value;
  endfunction

endpackage

// File: rtl/score_bcd_counter_bcd_digit.sv
// One BCD decade with increment/decrement enables, carry-out and borrow-out.
// inc and dec are never asserted together by the parent.
module bcd_digit
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output bcd_digit_t digit,
  output logic       carry,
  output logic       borrow
);

  bcd_digit_t digit_reg;

  // Decade register: clear wins, then count up 0..9 or down 9..0 with rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg <= '0;
    end else if (clr) begin
      digit_reg <= '0;
    end else if (inc) begin
      digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
    end else if (dec) begin
      digit_reg <= (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
    end
  end

  assign digit  = digit_reg;
  assign carry  = inc && (digit_reg == 4'd9);
  assign borrow = dec && (digit_reg == 4'd0);

endmodule

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter feeding the per-digit seven-segment decoders.
// Handles edge detection of increment/decrement, saturation or wrap at
// MAX_SCORE, leading-zero blanking and the end-of-range indication.
// Optional feature: define SCORE_BLINK_EN to blink the display when an
// increment hits the top of the range.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int MAX_SCORE    = 99,
  parameter int WRAP         = 0,
  parameter int BLINK_TICKS  = 12_500_000,
  parameter int BLINK_CYCLES = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Incr,
  input  logic       i_Decr,
  input  logic       i_Clear,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Max,
  output logic       o_Wrap
);

  localparam bcd_digit_t MAX_TENS = bcd_digit_t'(MAX_SCORE / 10);
  localparam bcd_digit_t MAX_ONES = bcd_digit_t'(MAX_SCORE % 10);

  logic incr_sync_reg, incr_prev_reg;
  logic decr_sync_reg, decr_prev_reg;
  logic wrap_reg;

  // Two-stage edge detector per request: the extra stage gives the fixed
  // two-cycle input-to-display latency and makes a held level count once.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      incr_sync_reg <= 1'b0;
      incr_prev_reg <= 1'b0;
      decr_sync_reg <= 1'b0;
      decr_prev_reg <= 1'b0;
    end else begin
      incr_sync_reg <= i_Incr;
      incr_prev_reg <= incr_sync_reg;
      decr_sync_reg <= i_Decr;
      decr_prev_reg <= decr_sync_reg;
    end
  end

  logic incr_edge, decr_edge, inc_only, dec_only;
  logic at_max, at_zero;
  logic step_inc, step_dec, wrap_hit, blink_trigger, digit_clr;

  bcd_digit_t digits [2];   // [0] = ones, [1] = tens
  logic [2:0] inc_chain;
  logic [2:0] dec_chain;

  assign incr_edge = incr_sync_reg && !incr_prev_reg;
  assign decr_edge = decr_sync_reg && !decr_prev_reg;
  assign inc_only  = incr_edge && !decr_edge;
  assign dec_only  = decr_edge && !incr_edge;

  assign at_max  = (digits[1] == MAX_TENS) && (digits[0] == MAX_ONES);
  assign at_zero = (digits[1] == 4'd0) && (digits[0] == 4'd0);

  // Clear has top priority; simultaneous edges cancel; range ends hold or wrap.
  assign step_inc      = !i_Clear && inc_only && !at_max;
  assign step_dec      = !i_Clear && dec_only && !at_zero;
  assign wrap_hit      = (WRAP != 0) && !i_Clear && inc_only && at_max;
  assign blink_trigger = !i_Clear && inc_only && at_max;
  assign digit_clr     = i_Clear || wrap_hit;

  assign inc_chain[0] = step_inc;
  assign dec_chain[0] = step_dec;

  // Ones decade first; each higher decade steps on the carry/borrow below it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_decade
    bcd_digit u_digit (
      .clk    (i_Clk),
      .rst_n  (i_Rst_L),
      .clr    (digit_clr),
      .inc    (inc_chain[gi]),
      .dec    (dec_chain[gi]),
      .digit  (digits[gi]),
      .carry  (inc_chain[gi+1]),
      .borrow (dec_chain[gi+1])
    );
  end

  // The tens decade never overflows or underflows because the range ends
  // are handled above, so its carry and borrow have no consumer.
  logic unused_chain;
  assign unused_chain = inc_chain[2] ^ dec_chain[2];

  // One-cycle wrap pulse, aligned with the count returning to 00.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= wrap_hit;
    end
  end

  logic blink_blank;

`ifdef SCORE_BLINK_EN
  localparam int TICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int CYC_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICKS - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(BLINK_CYCLES - 1);

  blink_state_t      state_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [CYC_W-1:0]  cyc_reg;
  logic              blank_reg;

  // Blink sequencer: OFF/ON half-periods of BLINK_TICKS each, BLINK_CYCLES
  // pairs, restartable by a new trigger and aborted by clear.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg <= NORMAL;
      tick_reg  <= '0;
      cyc_reg   <= '0;
      blank_reg <= 1'b0;
    end else if (i_Clear) begin
      state_reg <= NORMAL;
      tick_reg  <= '0;
      cyc_reg   <= '0;
      blank_reg <= 1'b0;
    end else if (blink_trigger) begin
      state_reg <= BLINK_OFF;
      tick_reg  <= '0;
      cyc_reg   <= '0;
      blank_reg <= 1'b1;
    end else begin
      case (state_reg)
        NORMAL: begin
          blank_reg <= 1'b0;
        end
        BLINK_OFF: begin
          if (tick_reg == TICK_LAST) begin
            state_reg <= BLINK_ON;
            tick_reg  <= '0;
            blank_reg <= 1'b0;
          end else begin
            tick_reg <= tick_reg + TICK_W'(1);
          end
        end
        BLINK_ON: begin
          if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (cyc_reg == CYC_LAST) begin
              state_reg <= NORMAL;
              cyc_reg   <= '0;
              blank_reg <= 1'b0;
            end else begin
              state_reg <= BLINK_OFF;
              cyc_reg   <= cyc_reg + CYC_W'(1);
              blank_reg <= 1'b1;
            end
          end else begin
            tick_reg <= tick_reg + TICK_W'(1);
          end
        end
        default: begin
          state_reg <= NORMAL;
          tick_reg  <= '0;
          cyc_reg   <= '0;
          blank_reg <= 1'b0;
        end
      endcase
    end
  end

  assign blink_blank = blank_reg;
`else
  // No blinking in this build: the display always follows the count and the
  // blink timing parameters have no effect.
  localparam int unused_blink_cfg = BLINK_TICKS + BLINK_CYCLES;
  logic unused_blink;
  assign unused_blink = blink_trigger;
  assign blink_blank  = 1'b0;
`endif

  // Leading-zero blanking on tens, then optional whole-display blanking.
  assign o_Tens = show_digit(digits[1], blink_blank || (digits[1] == 4'd0));
  assign o_Ones = show_digit(digits[0], blink_blank);
  assign o_Max  = at_max;
  assign o_Wrap = wrap_reg;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter. Three instances share one
// stimulus stream: (99, saturate), (15, saturate) and (15, wrap). A bench
// model based on an integer score checks every output each cycle, and
// literal expectations pin the key scenarios.
module tb_score_bcd_counter;

  localparam int NI = 3;
  localparam int T  = 4;
  localparam int C  = 2;
  localparam int MAXV  [NI] = '{99, 15, 15};
  localparam int WRAPV [NI] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic incr = 1'b0;
  logic decr = 1'b0;
  logic clr = 1'b0;

  logic [3:0] tens [NI];
  logic [3:0] ones [NI];
  logic       mx   [NI];
  logic       wr   [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    score_bcd_counter #(
      .MAX_SCORE    (MAXV[gi]),
      .WRAP         (WRAPV[gi]),
      .BLINK_TICKS  (T),
      .BLINK_CYCLES (C)
    ) u_dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .i_Incr  (incr),
      .i_Decr  (decr),
      .i_Clear (clr),
      .o_Tens  (tens[gi]),
      .o_Ones  (ones[gi]),
      .o_Max   (mx[gi]),
      .o_Wrap  (wr[gi])
    );
  end

  int total = 0;
  int bad = 0;

  // Model state: integer score, wrap flag, blink activity and elapsed cycles.
  int m_cnt [NI];
  bit m_wrap [NI];
  bit m_act [NI];
  int m_el [NI];
  bit h_i1, h_i2, h_d1, h_d2;   // request levels seen at the last two clocks

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_act[k] = 0; m_el[k] = 0;
    end
    h_i1 = 0; h_i2 = 0; h_d1 = 0; h_d2 = 0;
  endtask

  task automatic model_step();
    bit ei, ed, trig;
    if (!rst_n) begin
      model_reset();
    end else begin
      ei = h_i1 && !h_i2;
      ed = h_d1 && !h_d2;
      for (int k = 0; k < NI; k++) begin
        m_wrap[k] = 0;
        trig = 0;
        if (clr) m_cnt[k] = 0;
        else if (ei && ed) m_cnt[k] = m_cnt[k];
        else if (ei) begin
          if (m_cnt[k] == MAXV[k]) begin
            trig = 1;
            if (WRAPV[k] != 0) begin m_cnt[k] = 0; m_wrap[k] = 1; end
          end else m_cnt[k] = m_cnt[k] + 1;
        end else if (ed) begin
          if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
        end
`ifdef SCORE_BLINK_EN
        if (clr) m_act[k] = 0;
        else if (trig) begin m_act[k] = 1; m_el[k] = 0; end
        else if (m_act[k]) begin
          m_el[k] = m_el[k] + 1;
          if (m_el[k] >= 2 * T * C) m_act[k] = 0;
        end
`else
        m_act[k] = trig && 1'b0;
`endif
      end
      h_i2 = h_i1; h_i1 = incr;
      h_d2 = h_d1; h_d1 = decr;
    end
  endtask

  function automatic bit m_blank(input int k);
    return m_act[k] && (((m_el[k] / T) % 2) == 0);
  endfunction

  function automatic int exp_tens(input int k);
    if (m_blank(k) || (m_cnt[k] / 10) == 0) return 15;
    return m_cnt[k] / 10;
  endfunction

  function automatic int exp_ones(input int k);
    if (m_blank(k)) return 15;
    return m_cnt[k] % 10;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("model_tens[%0d]", k), 32'(tens[k]), exp_tens(k));
      chk($sformatf("model_ones[%0d]", k), 32'(ones[k]), exp_ones(k));
      chk($sformatf("model_max[%0d]", k), 32'(mx[k]), (m_cnt[k] == MAXV[k]) ? 1 : 0);
      chk($sformatf("model_wrap[%0d]", k), 32'(wr[k]), 32'(m_wrap[k]));
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_inc();
    incr = 1; cyc(); incr = 0; cyc();
  endtask

  task automatic pulse_dec();
    decr = 1; cyc(); decr = 0; cyc();
  endtask

  initial begin
    model_reset();
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    chk("reset_tens", 32'(tens[0]), 15);
    chk("reset_ones", 32'(ones[0]), 0);
    chk("reset_max", 32'(mx[0]), 0);
    chk("reset_wrap", 32'(wr[2]), 0);

    repeat (12) pulse_inc();
    chk("twelve_tens", 32'(tens[0]), 1);
    chk("twelve_ones", 32'(ones[0]), 2);

    incr = 1; repeat (50) cyc(); incr = 0; repeat (2) cyc();
    chk("held_once_ones", 32'(ones[0]), 3);

    repeat (2) pulse_inc();
    chk("at15_max_sat", 32'(mx[1]), 1);
    chk("at15_max_wrap", 32'(mx[2]), 1);
    chk("at15_max_big", 32'(mx[0]), 0);

    // Increment at the top of the range: hold for instance 1, wrap for instance 2.
    pulse_inc();
    chk("wrap_pulse", 32'(wr[2]), 1);
    chk("wrap_max_low", 32'(mx[2]), 0);
    chk("sat_max_high", 32'(mx[1]), 1);
`ifdef SCORE_BLINK_EN
    chk("blink_off_tens", 32'(tens[1]), 15);
    chk("blink_off_ones", 32'(ones[1]), 15);
    for (int i = 1; i < 2 * T * C; i++) begin
      cyc();
      chk($sformatf("blink_ones_c%0d", i), 32'(ones[1]), (((i / T) % 2) == 0) ? 15 : 5);
    end
    cyc();
    chk("blink_done_tens", 32'(tens[1]), 1);
    chk("blink_done_ones", 32'(ones[1]), 5);
`else
    chk("sat_tens", 32'(tens[1]), 1);
    chk("sat_ones", 32'(ones[1]), 5);
    chk("wrap_tens", 32'(tens[2]), 15);
    chk("wrap_ones", 32'(ones[2]), 0);
    cyc();
    chk("wrap_single", 32'(wr[2]), 0);
`endif

    clr = 1; cyc(); clr = 0; cyc();
    chk("clear_tens", 32'(tens[0]), 15);
    chk("clear_ones", 32'(ones[0]), 0);

    repeat (9) pulse_inc();
    chk("nine_tens", 32'(tens[0]), 15);
    chk("nine_ones", 32'(ones[0]), 9);
    pulse_inc();
    chk("carry_tens", 32'(tens[0]), 1);
    chk("carry_ones", 32'(ones[0]), 0);
    pulse_dec();
    chk("borrow_tens", 32'(tens[0]), 15);
    chk("borrow_ones", 32'(ones[0]), 9);

    incr = 1; decr = 1; cyc(); incr = 0; decr = 0; cyc(); cyc();
    chk("both_edges_ones", 32'(ones[0]), 9);

    incr = 1; clr = 1; repeat (3) cyc(); incr = 0; clr = 0; repeat (2) cyc();
    chk("clear_incr_ones", 32'(ones[0]), 0);
    chk("clear_incr_tens", 32'(tens[0]), 15);

    pulse_dec();
    chk("dec_at_zero_ones", 32'(ones[0]), 0);
    chk("dec_at_zero_tens", 32'(tens[0]), 15);

    // Reach the top again, trigger once more, then reset asynchronously mid-cycle.
    repeat (16) pulse_inc();
    chk("pre_reset_max", 32'(mx[1]), 1);
    repeat (5) cyc();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("async_rst_tens", 32'(tens[1]), 15);
    chk("async_rst_ones", 32'(ones[1]), 0);
    chk("async_rst_max", 32'(mx[1]), 0);
    chk("async_rst_ones0", 32'(ones[0]), 0);
    cyc();
    rst_n = 1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_counter.md
# score_bcd_counter

Two-digit BCD score counter that converts debounced increment/decrement/clear requests into the tens and ones digit codes consumed by the seven-segment decoders. It sits directly upstream of the two per-digit segment decoders on the display path and owns leading-zero blanking and the end-of-range indication. Digit codes above 9 are reserved as "blank" and drive the decoders to all-segments-off.

## Interface
Parameters:
- MAX_SCORE, 99: upper count limit, 1..99.
- WRAP, 0: 0 saturates at MAX_SCORE; 1 wraps MAX_SCORE+1 to 0.
- BLINK_TICKS, 12_500_000: clock cycles per blink half-period (0.5 s at 25 MHz).
- BLINK_CYCLES, 3: number of full off/on blink cycles.

Ports:
- i_Clk  in  1  system clock; one clock domain; reset is asynchronous and active-low.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Incr  in  1  increment request, level, already synchronized and debounced.
- i_Decr  in  1  decrement request, same conditioning as i_Incr.
- i_Clear  in  1  synchronous clear, level-sensitive.
- o_Tens  out  4  tens digit code, 0..9 or 4'hF for blank.
- o_Ones  out  4  ones digit code, 0..9 or 4'hF for blank.
- o_Max  out  1  high while count == MAX_SCORE.
- o_Wrap  out  1  one-cycle pulse on wrap to 0 (WRAP=1 only).

## Operation
- Count state is held as two BCD decades (tens, ones), never binary.
- i_Incr and i_Decr are rising-edge detected internally; a held level counts once. Edge-detect registers reset to 0, so an input already high at reset release counts once.
- Priority per cycle:
  - i_Clear (level) wins and sets the count to 00.
  - If both edges occur in the same cycle, no change.
  - Otherwise an increment edge increments, then a decrement edge decrements.
- Increment:
  - ones 9 -> 0 with carry into tens.
  - At MAX_SCORE: WRAP=0 holds the count; WRAP=1 loads 00 and pulses o_Wrap.
- Decrement at 00 holds 00; no borrow-wrap in either mode.
- Leading-zero blanking: o_Tens = 4'hF when tens == 0. o_Ones always shows a digit, so 00 displays as " 0".
- o_Max is derived from registered count and is combinational.

## Timing
- Reset values: count 00, o_Tens 4'hF, o_Ones 0, o_Max 0 (1 if MAX_SCORE is 0, which is illegal), o_Wrap 0, blink FSM in NORMAL.
- Latency: input edge sampled at clock N; new digits visible after clock N+1. Edge detector adds 1 cycle, so 2 cycles from the input rising to the output change.
- Back-to-back edges need i_Incr low for at least 1 cycle between them; maximum count rate is one step per 2 cycles.
- Reset mid-blink or mid-count returns immediately to reset values.

## Configuration
- Macro SCORE_BLINK_EN defined:
  - On a saturating increment attempt at MAX_SCORE (WRAP=0), or on a wrap (WRAP=1), the FSM goes NORMAL -> BLINK_OFF.
  - BLINK_OFF: both outputs 4'hF.
  - BLINK_ON: normal digits.
  - Each state lasts BLINK_TICKS cycles; after BLINK_CYCLES OFF/ON pairs, return to NORMAL.
  - A new trigger during a blink restarts it from BLINK_OFF.
  - i_Clear aborts to NORMAL in the same cycle that it clears the count.
  - Counting continues during blink.
- Macro undefined: no FSM, tick counter or cycle counter is synthesized; outputs always follow the count.

## Structure
- Shared package score_pkg:
  - DIGIT_BLANK = 4'hF.
  - bcd_digit_t: 4-bit typedef.
  - blink_state_t enum: NORMAL, BLINK_OFF, BLINK_ON.
- Sub-module bcd_digit:
  - One decade with inc/dec enables, carry-out and borrow-out.
  - Instantiated twice: tens enabled by the ones carry/borrow.

## Test plan
- Reset, then 12 separate i_Incr pulses -> o_Tens=1, o_Ones=2; before the first pulse o_Tens=4'hF, o_Ones=0.
- i_Incr held high for 50 cycles -> count increments exactly once.
- From 09, one increment -> 10 (carry). From 10, one decrement -> 09, with o_Tens blanked (4'hF).
- WRAP=0, MAX_SCORE=15, count 15: increment -> stays 15 and o_Max=1. WRAP=1: increment -> 00, 1-cycle o_Wrap, o_Max=0.
- i_Incr and i_Decr edges in the same cycle -> no change. i_Clear together with i_Incr -> 00.
- SCORE_BLINK_EN, BLINK_TICKS=4, BLINK_CYCLES=2, saturate at max:
  - Outputs are 4'hF for 4 cycles, digits for 4, 4'hF for 4, digits for 4, then NORMAL.
  - Asserting i_Rst_L low mid-blink -> immediate reset values.
